// File: rtl/perf_sampler.sv
// Periodic sampler: reads an event counter every P+1 cycles, queues the samples in a FIFO, keeps a saturating total.
// Sample captured combinationally in the SAMPLE cycle and written on the following edge; pop is valid/ready.
module perf_sampler #(
  parameter int CNT_W = 4,
  parameter int ACC_W = 16,
  parameter int DEPTH = 4,
  parameter int PER_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en_i,
  input  logic                       clr_i,
  input  logic [PER_W-1:0]           period_i,
  input  logic [CNT_W-1:0]           p_count_i,
  output logic                       sw_req_o,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [CNT_W-1:0]           rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic [ACC_W-1:0]           total_o,
  output logic                       ovf_o,
  output logic                       drop_o
);

  localparam int LVL_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, COUNT, SAMPLE} state_t;

  state_t             r_state, w_state_nxt;
  logic [PER_W-1:0]   r_timer, w_timer_nxt;
  logic [PER_W-1:0]   w_per;

  logic [CNT_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic [ACC_W-1:0]   r_total;
  logic               r_ovf, r_drop;

  logic               w_push, w_pop, w_full, w_wr, w_drop;
  logic [ACC_W:0]     w_sum;

  // A zero period behaves as one so the sampler never stalls in COUNT.
  assign w_per = (period_i == '0) ? PER_W'(1) : period_i;

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    case (r_state)
      IDLE: begin
        if (en_i) begin
          w_state_nxt = COUNT;
          w_timer_nxt = '0;
        end
      end
      COUNT: begin
        if (!en_i) begin
          w_state_nxt = IDLE;
          w_timer_nxt = '0;
        end else if (r_timer >= w_per - PER_W'(1)) begin
          w_state_nxt = SAMPLE;
        end else begin
          w_timer_nxt = r_timer + PER_W'(1);
        end
      end
      SAMPLE: begin
        w_state_nxt = en_i ? COUNT : IDLE;
        w_timer_nxt = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_timer_nxt = '0;
      end
    endcase
    if (clr_i) begin
      w_state_nxt = IDLE;
      w_timer_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  assign sw_req_o = (r_state == SAMPLE);

  // A full FIFO still accepts the new sample when the head leaves in the same cycle.
  assign w_push = (r_state == SAMPLE);
  assign w_pop  = (r_level != '0) && rd_ready_i;
  assign w_full = (r_level == LVL_W'(DEPTH));
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_drop = w_push && w_full && !w_pop;
  assign w_sum  = {1'b0, r_total} + (ACC_W+1)'(p_count_i);

  always_ff @(posedge clk) begin
    if (w_wr && !clr_i)
      r_mem[r_wr_ptr] <= p_count_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_total  <= '0;
      r_ovf    <= 1'b0;
      r_drop   <= 1'b0;
    end else if (clr_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_total  <= '0;
      r_ovf    <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      if (w_wr)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop)
        r_drop <= 1'b1;
      if (w_push) begin
        if (w_sum[ACC_W]) begin
          r_total <= '1;
          r_ovf   <= 1'b1;
        end else begin
          r_total <= w_sum[ACC_W-1:0];
        end
      end
    end
  end

  assign rd_valid_o = (r_level != '0);
  assign rd_data_o  = rd_valid_o ? r_mem[r_rd_ptr] : '0;
  assign level_o    = r_level;
  assign total_o    = r_total;
  assign ovf_o      = r_ovf;
  assign drop_o     = r_drop;

endmodule

// File: tb/tb_perf_sampler.sv
// Directed bench for perf_sampler (ACC_W=8 so saturation is reachable quickly).
module tb_perf_sampler;

  localparam int CNT_W = 4;
  localparam int ACC_W = 8;
  localparam int DEPTH = 4;
  localparam int PER_W = 8;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       en_i;
  logic                       clr_i;
  logic [PER_W-1:0]           period_i;
  logic [CNT_W-1:0]           p_count_i;
  logic                       sw_req_o;
  logic                       rd_valid_o;
  logic                       rd_ready_i;
  logic [CNT_W-1:0]           rd_data_o;
  logic [$clog2(DEPTH+1)-1:0] level_o;
  logic [ACC_W-1:0]           total_o;
  logic                       ovf_o;
  logic                       drop_o;

  int vectors = 0;
  int miscompares = 0;

  perf_sampler #(.CNT_W(CNT_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .PER_W(PER_W)) dut (
    .clk(clk), .reset(reset), .en_i(en_i), .clr_i(clr_i), .period_i(period_i),
    .p_count_i(p_count_i), .sw_req_o(sw_req_o), .rd_valid_o(rd_valid_o),
    .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o), .level_o(level_o),
    .total_o(total_o), .ovf_o(ovf_o), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps until sw_req_o is seen; n is the number of edges taken (bounded).
  task automatic wait_req(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sw_req_o && n < 64);
  endtask

  initial begin
    int n;
    int pulses;
    reset = 1'b1; en_i = 1'b0; clr_i = 1'b0; period_i = 8'd3;
    p_count_i = 4'd5; rd_ready_i = 1'b0;
    repeat (2) step();
    chk("rst_sw_req", sw_req_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_total", total_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_drop", drop_o, 0);
    reset = 1'b0;
    step();

    // period 3, constant count 5: pulses every 4 cycles
    en_i = 1'b1;
    wait_req(n); chk("p3_first_latency", n, 4);
    wait_req(n); chk("p3_spacing1", n, 4);
    wait_req(n); chk("p3_spacing2", n, 4);
    step();
    chk("p3_level", level_o, 3);
    chk("p3_total", total_o, 15);
    chk("p3_head", rd_data_o, 5);
    en_i = 1'b0; rd_ready_i = 1'b1;
    repeat (3) step();
    chk("p3_drained_level", level_o, 0);
    chk("p3_empty_data", rd_data_o, 0);
    clr_i = 1'b1; step(); clr_i = 1'b0;
    chk("clr_total", total_o, 0);

    // overflow of a full FIFO: 6 samples of 2 with no reader
    rd_ready_i = 1'b0; p_count_i = 4'd2; en_i = 1'b1;
    for (int i = 0; i < 6; i++) wait_req(n);
    step();
    en_i = 1'b0;
    chk("full_level", level_o, 4);
    chk("full_drop", drop_o, 1);
    chk("full_total", total_o, 12);
    rd_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("full_drain_data", rd_data_o, 2);
      step();
    end
    chk("full_drain_level", level_o, 0);
    chk("full_drain_valid", rd_valid_o, 0);
    rd_ready_i = 1'b0;
    clr_i = 1'b1; step(); clr_i = 1'b0;

    // full FIFO with simultaneous pop and push, period 1
    period_i = 8'd1; en_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      p_count_i = CNT_W'(k);
      wait_req(n);
      step();
    end
    chk("pp_prefill_level", level_o, 4);
    p_count_i = 4'd9;
    wait_req(n); chk("p1_spacing", n, 1);
    rd_ready_i = 1'b1; en_i = 1'b0;
    step();
    chk("pp_level", level_o, 4);
    chk("pp_drop", drop_o, 0);
    chk("pp_d0", rd_data_o, 2); step();
    chk("pp_d1", rd_data_o, 3); step();
    chk("pp_d2", rd_data_o, 4); step();
    chk("pp_tail", rd_data_o, 9); step();
    chk("pp_level_end", level_o, 0);
    chk("pp_total", total_o, 8'h13);

    // saturation with ACC_W=8, count 15
    clr_i = 1'b1; step(); clr_i = 1'b0;
    p_count_i = 4'd15; en_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wait_req(n);
      step();
    end
    chk("sat17_total", total_o, 8'hFF);
    for (int i = 0; i < 2; i++) begin
      wait_req(n);
      step();
    end
    chk("sat_total_hold", total_o, 8'hFF);
    chk("sat_ovf", ovf_o, 1);
    en_i = 1'b0; step();
    clr_i = 1'b1; step(); clr_i = 1'b0;
    chk("sat_clr_ovf", ovf_o, 0);

    // enable dropped mid-count, then re-enabled
    rd_ready_i = 1'b0; period_i = 8'd5; p_count_i = 4'd7;
    en_i = 1'b1;
    step(); step();
    en_i = 1'b0;
    pulses = 0;
    repeat (8) begin
      step();
      if (sw_req_o) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    chk("abort_level", level_o, 0);
    en_i = 1'b1;
    wait_req(n); chk("reenable_latency", n, 6);
    step();
    wait_req(n); chk("p5_spacing", n, 5);
    step();
    chk("p5_level", level_o, 2);
    wait_req(n);

    // clear during a SAMPLE cycle
    clr_i = 1'b1; step(); clr_i = 1'b0;
    chk("clr_level", level_o, 0);
    chk("clr_total2", total_o, 0);
    chk("clr_sw_req", sw_req_o, 0);
    chk("clr_valid", rd_valid_o, 0);
    wait_req(n); chk("clr_idle_latency", n, 6);

    // reset during a SAMPLE cycle
    reset = 1'b1; #1;
    chk("arst_sw_req", sw_req_o, 0);
    step();
    reset = 1'b0; en_i = 1'b0;
    step();
    chk("arst_level", level_o, 0);
    chk("arst_total", total_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
